// File: rtl/bubble_host_sequencer.sv
// Host-side bubble memory sequencer: drives nBSS/nBSEN/nREPEN/nBOOTEN for boot and page reads.
// Optional ABORT input is added when BUBBLE_SEQ_ABORT_EN is defined.
module bubble_host_sequencer #(
  parameter int BCYC        = 480,
  parameter int BOOT_CYCLES = 4204,
  parameter int PAGE_CYCLES = 682
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        START,
  input  logic        MODE,
  input  logic [11:0] PAGE,
`ifdef BUBBLE_SEQ_ABORT_EN
  input  logic        ABORT,
`endif
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [11:0] POS,
  output logic        nBSS,
  output logic        nBSEN,
  output logic        nREPEN,
  output logic        nBOOTEN,
  output logic        nINCTRL
);

  localparam int CW = $clog2(BCYC);
  localparam int NW = $clog2(BOOT_CYCLES + PAGE_CYCLES + 1);
  localparam logic [11:0]   POS_MAX   = 12'd2052;
  localparam logic [11:0]   POS_RST   = 12'd2051;
  localparam logic [CW-1:0] CYC_LAST  = CW'(BCYC - 1);
  localparam logic [CW-1:0] BSS_LAST  = CW'(95);
  localparam logic [CW-1:0] REP_LEN   = CW'(48);
  localparam logic [NW-1:0] BOOT_LAST = NW'(BOOT_CYCLES - 1);
  localparam logic [NW-1:0] PAGE_LAST = NW'(PAGE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BSS,
    S_SETTLE,
    S_BOOT,
    S_SEEK,
    S_PAGE,
    S_TAIL
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [NW-1:0] bcnt, bcnt_n;
  logic [11:0]   pos_n, pos_inc;
  logic [11:0]   page_r, page_n;
  logic          mode_r, mode_n;
  logic          busy_n, err_n, fin, fin_n;
  logic          bss_n, bsen_n, repen_n, booten_n;
  logic          last, run, hit, rep_on, abort;

`ifdef BUBBLE_SEQ_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif

  assign last    = (cyc == CYC_LAST);
  assign run     = (state == S_BOOT) || (state == S_SEEK) ||
                   (state == S_PAGE);
  assign hit     = (state == S_SEEK) && (cyc == '0) &&
                   (POS == page_r);
  assign pos_inc = (POS == POS_MAX) ? 12'd0 : POS + 12'd1;
  assign rep_on  = ((state == S_BOOT) && (cyc < REP_LEN)) ||
                   ((state == S_PAGE) && (bcnt == '0) &&
                    (cyc < REP_LEN)) ||
                   hit;

  // Pins are decoded from the current state and land one clock later.
  always_comb begin
    state_n  = state;
    cyc_n    = last ? '0 : cyc + CW'(1);
    bcnt_n   = bcnt;
    pos_n    = POS;
    page_n   = page_r;
    mode_n   = mode_r;
    busy_n   = fin ? 1'b0 : BUSY;
    err_n    = 1'b0;
    fin_n    = 1'b0;
    bss_n    = (state != S_BSS);
    bsen_n   = !(run && !abort);
    repen_n  = !(rep_on && !abort);
    booten_n = nBOOTEN;
    if ((state == S_TAIL) || (run && abort))
      booten_n = 1'b1;
    unique case (state)
      S_IDLE: begin
        cyc_n = '0;
        if (START && !BUSY) begin
          if (!MODE && (PAGE > POS_MAX)) begin
            err_n = 1'b1;
          end else begin
            busy_n   = 1'b1;
            booten_n = ~MODE;
            mode_n   = MODE;
            page_n   = PAGE;
            state_n  = S_BSS;
          end
        end
      end
      S_BSS: begin
        if (cyc == BSS_LAST)
          state_n = S_SETTLE;
      end
      S_SETTLE: begin
        if (last) begin
          state_n = mode_r ? S_BOOT : S_SEEK;
          bcnt_n  = '0;
        end
      end
      S_BOOT: begin
        if (last) begin
          pos_n = pos_inc;
          if (bcnt == BOOT_LAST)
            state_n = S_TAIL;
          else
            bcnt_n = bcnt + NW'(1);
        end
      end
      S_SEEK: begin
        if (hit) begin
          state_n = S_PAGE;
          bcnt_n  = '0;
        end
        if (last)
          pos_n = pos_inc;
      end
      S_PAGE: begin
        if (last) begin
          pos_n = pos_inc;
          if (bcnt == PAGE_LAST)
            state_n = S_TAIL;
          else
            bcnt_n = bcnt + NW'(1);
        end
      end
      S_TAIL: begin
        if (last) begin
          state_n = S_IDLE;
          fin_n   = 1'b1;
        end
      end
    endcase
    // Abort skips the pin lag, so TAIL starts one count in.
    if (run && abort) begin
      state_n = S_TAIL;
      cyc_n   = CW'(1);
      pos_n   = POS;
    end
  end

  always_ff @(posedge MCLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      cyc     <= '0;
      bcnt    <= '0;
      POS     <= POS_RST;
      page_r  <= '0;
      mode_r  <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      fin     <= 1'b0;
      nBSS    <= 1'b1;
      nBSEN   <= 1'b1;
      nREPEN  <= 1'b1;
      nBOOTEN <= 1'b1;
      nINCTRL <= 1'b1;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      bcnt    <= bcnt_n;
      POS     <= pos_n;
      page_r  <= page_n;
      mode_r  <= mode_n;
      BUSY    <= busy_n;
      DONE    <= fin;
      ERR     <= err_n;
      fin     <= fin_n;
      nBSS    <= bss_n;
      nBSEN   <= bsen_n;
      nREPEN  <= repen_n;
      nBOOTEN <= booten_n;
      nINCTRL <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bubble_host_sequencer.sv
// Bench for bubble_host_sequencer: event monitor plus arithmetic model of pin timing and POS.
// Exercises ABORT too when BUBBLE_SEQ_ABORT_EN is defined.
module tb_bubble_host_sequencer;

  localparam int BCYC = 120;
  localparam int BC   = 12;
  localparam int PC   = 6;
  localparam int NPOS = 2053;

  logic        MCLK  = 1'b0;
  logic        RST   = 1'b1;
  logic        START = 1'b0;
  logic        MODE  = 1'b0;
  logic [11:0] PAGE  = '0;
`ifdef BUBBLE_SEQ_ABORT_EN
  logic        ABORT = 1'b0;
`endif
  logic        BUSY, DONE, ERR;
  logic [11:0] POS;
  logic        nBSS, nBSEN, nREPEN, nBOOTEN, nINCTRL;

  bubble_host_sequencer #(
    .BCYC(BCYC),
    .BOOT_CYCLES(BC),
    .PAGE_CYCLES(PC)
  ) dut (
    .MCLK(MCLK),
    .RST(RST),
    .START(START),
    .MODE(MODE),
    .PAGE(PAGE),
`ifdef BUBBLE_SEQ_ABORT_EN
    .ABORT(ABORT),
`endif
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR),
    .POS(POS),
    .nBSS(nBSS),
    .nBSEN(nBSEN),
    .nREPEN(nREPEN),
    .nBOOTEN(nBOOTEN),
    .nINCTRL(nINCTRL)
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int passed = 0;
  int mpos   = 2051;
  int tick   = 0;

  always @(posedge MCLK) tick <= tick + 1;

  logic p_bss = 1'b1, p_bsen = 1'b1, p_rep = 1'b1;
  int bss_fall = 0, bss_rise = 0, bsen_fall = 0, bsen_rise = 0;
  int rep_fall = 0, rep_pos = 0, rep_cnt = 0, rep_bad = 0;
  int done_cnt = 0, done_t = 0, err_cnt = 0, boot_low = 0, viol = 0;

  // Edge timestamps, counted in rising MCLK edges.
  always @(negedge MCLK) begin
    if (p_bss && !nBSS) bss_fall = tick;
    if (!p_bss && nBSS) bss_rise = tick;
    if (p_bsen && !nBSEN) bsen_fall = tick;
    if (!p_bsen && nBSEN) bsen_rise = tick;
    if (p_rep && !nREPEN) begin
      rep_fall = tick;
      rep_pos  = int'(POS);
      rep_cnt++;
    end
    if (!p_rep && nREPEN && (tick - rep_fall != 48)) rep_bad++;
    if (DONE) begin
      done_cnt++;
      done_t = tick;
    end
    if (ERR) err_cnt++;
    if (!nBOOTEN) boot_low++;
    if ((!nREPEN && nBSEN) || (!nBSS && !nBSEN) || (DONE && ERR))
      viol++;
    p_bss  = nBSS;
    p_bsen = nBSEN;
    p_rep  = nREPEN;
  end

  task automatic step;
    @(negedge MCLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    step;
    step;
    checks++;
    if ({nBSS, nBSEN, nREPEN, nBOOTEN, nINCTRL} !== 5'h1f)
      $display("FAIL reset_pins: got %b want 11111",
               {nBSS, nBSEN, nREPEN, nBOOTEN, nINCTRL});
    else passed++;
    checks++;
    if ({BUSY, DONE, ERR} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {BUSY, DONE, ERR});
    else passed++;
    checks++;
    if (POS !== 12'd2051)
      $display("FAIL reset_pos: got %0d want 2051", POS);
    else passed++;
    RST = 1'b0;
    step;
    checks++;
    if (nINCTRL !== 1'b0)
      $display("FAIL inctrl: got %b want 0", nINCTRL);
    else passed++;
    mpos = 2051;
  endtask

  task automatic test_page_read(input int page);
    int p0, k, acc, n, d0, r0, b0, o0, want;
    p0 = mpos;
    k  = (page - p0 + NPOS) % NPOS;
    d0 = done_cnt; r0 = rep_cnt; b0 = rep_bad; o0 = boot_low;
    START = 1'b1; MODE = 1'b0; PAGE = 12'(page);
    acc = tick + 1;
    step;
    START = 1'b0;
    PAGE  = 12'($urandom_range(0, 4095));
    checks++;
    if ({BUSY, nBOOTEN} !== 2'b11)
      $display("FAIL page_accept p=%0d: got %b want 11",
               page, {BUSY, nBOOTEN});
    else passed++;
    n = 0;
    while (done_cnt == d0 && n < (k + PC + 8) * BCYC) begin
      step;
      n++;
    end
    checks++;
    if (done_cnt == d0)
      $display("FAIL page_done p=%0d: got timeout want DONE", page);
    else passed++;
    checks++;
    if (bss_fall != acc + 1 || bss_rise - bss_fall != 96)
      $display("FAIL page_bss p=%0d: got fall %0d len %0d want %0d 96",
               page, bss_fall, bss_rise - bss_fall, acc + 1);
    else passed++;
    checks++;
    if (bsen_fall - bss_fall != BCYC)
      $display("FAIL page_bsen_lat p=%0d: got %0d want %0d",
               page, bsen_fall - bss_fall, BCYC);
    else passed++;
    checks++;
    want = (k + PC) * BCYC;
    if (bsen_rise - bsen_fall != want)
      $display("FAIL page_bsen_len p=%0d: got %0d want %0d",
               page, bsen_rise - bsen_fall, want);
    else passed++;
    checks++;
    if (rep_cnt - r0 != 1 || rep_bad != b0)
      $display("FAIL page_rep_cnt p=%0d: got %0d bad %0d want 1 0",
               page, rep_cnt - r0, rep_bad - b0);
    else passed++;
    checks++;
    if (rep_fall - bsen_fall != k * BCYC || rep_pos != page)
      $display("FAIL page_rep_at p=%0d: got %0d pos %0d want %0d %0d",
               page, rep_fall - bsen_fall, rep_pos, k * BCYC, page);
    else passed++;
    checks++;
    if (done_t - bsen_rise != BCYC)
      $display("FAIL page_done_lat p=%0d: got %0d want %0d",
               page, done_t - bsen_rise, BCYC);
    else passed++;
    checks++;
    want = (p0 + k + PC) % NPOS;
    if (POS !== 12'(want) || BUSY !== 1'b0 || boot_low != o0)
      $display("FAIL page_end p=%0d: got pos %0d busy %b bootlow %0d want %0d 0 0",
               page, POS, BUSY, boot_low - o0, want);
    else passed++;
    mpos = want;
  endtask

  task automatic test_boot;
    int p0, acc, n, d0, r0, b0, want;
    p0 = mpos;
    d0 = done_cnt; r0 = rep_cnt; b0 = rep_bad;
    START = 1'b1; MODE = 1'b1; PAGE = 12'($urandom_range(0, 4095));
    acc = tick + 1;
    step;
    START = 1'b0;
    checks++;
    if ({BUSY, nBOOTEN} !== 2'b10)
      $display("FAIL boot_accept: got %b want 10", {BUSY, nBOOTEN});
    else passed++;
    n = 0;
    while (done_cnt == d0 && n < (BC + 8) * BCYC) begin
      step;
      n++;
    end
    checks++;
    if (done_cnt == d0)
      $display("FAIL boot_done: got timeout want DONE");
    else passed++;
    checks++;
    if (bss_fall != acc + 1 || bss_rise - bss_fall != 96)
      $display("FAIL boot_bss: got fall %0d len %0d want %0d 96",
               bss_fall, bss_rise - bss_fall, acc + 1);
    else passed++;
    checks++;
    if (bsen_fall - bss_fall != BCYC ||
        bsen_rise - bsen_fall != BC * BCYC)
      $display("FAIL boot_bsen: got lat %0d len %0d want %0d %0d",
               bsen_fall - bss_fall, bsen_rise - bsen_fall,
               BCYC, BC * BCYC);
    else passed++;
    checks++;
    if (rep_cnt - r0 != BC || rep_bad != b0)
      $display("FAIL boot_rep: got %0d bad %0d want %0d 0",
               rep_cnt - r0, rep_bad - b0, BC);
    else passed++;
    checks++;
    if (done_t - bsen_rise != BCYC)
      $display("FAIL boot_done_lat: got %0d want %0d",
               done_t - bsen_rise, BCYC);
    else passed++;
    checks++;
    want = (p0 + BC) % NPOS;
    if (POS !== 12'(want) || {BUSY, nBOOTEN} !== 2'b01)
      $display("FAIL boot_end: got pos %0d busy/booten %b want %0d 01",
               POS, {BUSY, nBOOTEN}, want);
    else passed++;
    mpos = want;
  endtask

  task automatic test_err;
    int pg;
    for (int i = 0; i < 2; i++) begin
      pg = (i == 0) ? 2053 : int'($urandom_range(2053, 4095));
      START = 1'b1; MODE = 1'b0; PAGE = 12'(pg);
      step;
      START = 1'b0;
      checks++;
      if ({ERR, BUSY} !== 2'b10 ||
          {nBSS, nBSEN, nREPEN, nBOOTEN} !== 4'hf)
        $display("FAIL err_pulse p=%0d: got err/busy %b pins %b want 10 1111",
                 pg, {ERR, BUSY}, {nBSS, nBSEN, nREPEN, nBOOTEN});
      else passed++;
      step;
      checks++;
      if ({ERR, BUSY} !== 2'b00)
        $display("FAIL err_width p=%0d: got %b want 00", pg, {ERR, BUSY});
      else passed++;
    end
  endtask

  task automatic test_busy_start;
    int p0, k, n, d0, e0, o0, want;
    p0 = mpos;
    k  = 3;
    d0 = done_cnt; e0 = err_cnt; o0 = boot_low;
    START = 1'b1; MODE = 1'b0; PAGE = 12'((p0 + k) % NPOS);
    step;
    START = 1'b0;
    repeat (300) step;
    START = 1'b1; MODE = 1'b0; PAGE = 12'd4000;
    step;
    START = 1'b1; MODE = 1'b1;
    step;
    START = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < (k + PC + 8) * BCYC) begin
      step;
      n++;
    end
    checks++;
    if (done_cnt == d0 || err_cnt != e0 || boot_low != o0)
      $display("FAIL busy_start: got done %0d err %0d bootlow %0d want 1 0 0",
               done_cnt - d0, err_cnt - e0, boot_low - o0);
    else passed++;
    checks++;
    want = (p0 + k + PC) % NPOS;
    if (POS !== 12'(want) || bsen_rise - bsen_fall != (k + PC) * BCYC)
      $display("FAIL busy_start_end: got pos %0d len %0d want %0d %0d",
               POS, bsen_rise - bsen_fall, want, (k + PC) * BCYC);
    else passed++;
    mpos = want;
  endtask

  task automatic test_rst_mid;
    int b0, n, d0;
    b0 = bsen_fall;
    START = 1'b1; MODE = 1'b1;
    step;
    START = 1'b0;
    n = 0;
    while (bsen_fall == b0 && n < 3 * BCYC) begin
      step;
      n++;
    end
    repeat (2 * BCYC + 100) step;
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({nBSS, nBSEN, nREPEN, nBOOTEN} !== 4'hf || POS !== 12'd2051 ||
        BUSY !== 1'b0)
      $display("FAIL rst_mid: got pins %b pos %0d busy %b want 1111 2051 0",
               {nBSS, nBSEN, nREPEN, nBOOTEN}, POS, BUSY);
    else passed++;
    step;
    RST = 1'b0;
    d0 = done_cnt;
    repeat (3 * BCYC) step;
    checks++;
    if (done_cnt != d0 || BUSY !== 1'b0)
      $display("FAIL rst_mid_done: got %0d busy %b want 0 0",
               done_cnt - d0, BUSY);
    else passed++;
    mpos = 2051;
    test_page_read(2051);
  endtask

`ifdef BUBBLE_SEQ_ABORT_EN
  task automatic test_abort;
    int p0, b0, r0, d0, n, ae, want;
    p0 = mpos;
    b0 = bsen_fall; r0 = rep_cnt; d0 = done_cnt;
    START = 1'b1; MODE = 1'b0; PAGE = 12'((p0 + 100) % NPOS);
    step;
    START = 1'b0;
    n = 0;
    while (bsen_fall == b0 && n < 3 * BCYC) begin
      step;
      n++;
    end
    repeat (9 * BCYC + 30) step;
    ABORT = 1'b1;
    step;
    ABORT = 1'b0;
    ae = tick;
    checks++;
    if (nBSEN !== 1'b1 || nREPEN !== 1'b1)
      $display("FAIL abort_pins: got %b want 11", {nBSEN, nREPEN});
    else passed++;
    n = 0;
    while (done_cnt == d0 && n < 3 * BCYC) begin
      step;
      n++;
    end
    checks++;
    if (done_cnt == d0 || done_t - ae != BCYC)
      $display("FAIL abort_done: got %0d want %0d", done_t - ae, BCYC);
    else passed++;
    checks++;
    want = (p0 + 9) % NPOS;
    if (POS !== 12'(want) || rep_cnt != r0 || BUSY !== 1'b0)
      $display("FAIL abort_end: got pos %0d rep %0d busy %b want %0d 0 0",
               POS, rep_cnt - r0, BUSY, want);
    else passed++;
    mpos = want;
  endtask
`endif

  initial begin
    test_reset;
    test_page_read(2);
    test_reset;
    test_page_read(2051);
    test_boot;
    test_err;
    test_busy_start;
    for (int i = 0; i < 4; i++)
      test_page_read((mpos + int'($urandom_range(0, 10))) % NPOS);
    test_rst_mid;
`ifdef BUBBLE_SEQ_ABORT_EN
    test_abort;
`endif
    checks++;
    if (viol != 0)
      $display("FAIL pin_order: got %0d bad clocks want 0", viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
